lieat_axi_rd_arb: RTL

LIEAT_AXI_RD_ARB -- requirements
Module: lieat_axi_rd_arb

---
 rtl/lieat_pkg.sv | 25 ++
 rtl/lieat_axi_rd_arb_if.sv | 30 +++
 rtl/lieat_rr_arb2.sv | 33 +++
 rtl/lieat_axi_rd_arb.sv | 130 +++++++++++++
 4 files changed

// File: rtl/lieat_pkg.sv
// Shared definitions for the lieat AXI read path: widths, AXI constants,
// arbiter grant encoding and the read-arbiter FSM state type.
package lieat_pkg;

  localparam int XLEN   = 32;
  localparam int AXILEN = 64;

  localparam logic [3:0] IC_ID      = 4'd0;
  localparam logic [3:0] DC_ID      = 4'd1;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [2:0] IC_SIZE    = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IC = 1'b0,
    GNT_DC = 1'b1
  } gnt_t;

endpackage

// File: rtl/lieat_axi_rd_arb_if.sv
// AXI read-address / read-data channel bundle between the arbiter (master)
// and the memory side (slave).
interface lieat_axi_rd_arb_if;
  import lieat_pkg::*;

  logic              arvalid;
  logic              arready;
  logic [XLEN-1:0]   araddr;
  logic [3:0]        arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [AXILEN-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [3:0]        rid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );

endinterface

// File: rtl/lieat_rr_arb2.sv
// Two-input round-robin arbiter. Grant is combinational from the requests;
// the last-granted client is registered and updated by the owner on upd.
module lieat_rr_arb2
  import lieat_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       upd,
  input  gnt_t       upd_gnt,
  output logic [1:0] gnt
);

  gnt_t last_q;

  // Remember who was served last; reset favours icache on the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)    last_q <= GNT_DC;
    else if (upd) last_q <= upd_gnt;
  end

  // Single requester wins outright; a tie goes to the one not served last.
  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_q == GNT_DC) ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/lieat_axi_rd_arb.sv
// Shares one AXI read port between icache line fills and dcache single
// reads, with exactly one transaction outstanding at a time.
module lieat_axi_rd_arb
  import lieat_pkg::*;
#(
  parameter logic [7:0] IC_ARLEN = 8'd3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ic_arvalid,
  output logic              ic_arready,
  input  logic [XLEN-1:0]   ic_araddr,
  output logic              ic_rvalid,
  input  logic              ic_rready,
  input  logic              dc_arvalid,
  output logic              dc_arready,
  input  logic [XLEN-1:0]   dc_araddr,
  input  logic [2:0]        dc_arsize,
  output logic              dc_rvalid,
  input  logic              dc_rready,
  output logic [AXILEN-1:0] rd_data,
  output logic              rd_last,
  output logic              rd_err,
  lieat_axi_rd_arb_if.master m
);

  state_t          state, nxt;
  gnt_t            grant_q;
  logic [XLEN-1:0] addr_q;
  logic [7:0]      len_q;
  logic [2:0]      size_q;
  logic [3:0]      id_q;
  logic [1:0]      gnt;
  logic            accept;
  logic            done;
  logic            m_rready;

  lieat_rr_arb2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     ({dc_arvalid, ic_arvalid}),
    .upd     (done),
    .upd_gnt (grant_q),
    .gnt     (gnt)
  );

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= nxt;
  end

  // Next state, client handshakes and R-channel steering.
  // arready is gated by reset so the comb pulse cannot leak while in reset.
  always_comb begin
    nxt        = state;
    accept     = 1'b0;
    done       = 1'b0;
    ic_arready = 1'b0;
    dc_arready = 1'b0;
    ic_rvalid  = 1'b0;
    dc_rvalid  = 1'b0;
    m_rready   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!reset && (ic_arvalid || dc_arvalid)) begin
          accept     = 1'b1;
          ic_arready = gnt[0];
          dc_arready = gnt[1];
          nxt        = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m.arready) nxt = ST_DATA;
      end
      ST_DATA: begin
        if (grant_q == GNT_IC) begin
          ic_rvalid = m.rvalid;
          m_rready  = ic_rready;
        end else begin
          dc_rvalid = m.rvalid;
          m_rready  = dc_rready;
        end
        if (m.rvalid && m_rready && m.rlast) begin
          done = 1'b1;
          nxt  = ST_IDLE;
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // Capture the winning request's AR fields at acceptance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_q <= GNT_IC;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      id_q    <= '0;
    end else if (accept) begin
      if (gnt[0]) begin
        grant_q <= GNT_IC;
        addr_q  <= ic_araddr & ~32'h7;
        len_q   <= IC_ARLEN;
        size_q  <= IC_SIZE;
        id_q    <= IC_ID;
      end else begin
        grant_q <= GNT_DC;
        addr_q  <= dc_araddr;
        len_q   <= '0;
        size_q  <= dc_arsize;
        id_q    <= DC_ID;
      end
    end
  end

  assign m.arvalid = (state == ST_ADDR);
  assign m.araddr  = addr_q;
  assign m.arid    = id_q;
  assign m.arlen   = len_q;
  assign m.arsize  = size_q;
  assign m.arburst = BURST_INCR;
  assign m.rready  = m_rready;

  assign rd_data = m.rdata;
  assign rd_last = m.rlast;
  assign rd_err  = m.rvalid & ((m.rresp != RESP_OKAY) | (m.rid != id_q));

endmodule
